// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined IEEE-754-style adder/subtractor.
//   S1 unpacks the operands, resolves special values and aligns the smaller operand.
//   S2 adds or subtracts the significands and normalises the result.
//   S3 rounds to nearest-even and packs the result and its flags.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake; a, b, op are sampled on transfer
//   a, b                operands (sign | exponent | fraction)
//   op                  0: a+b, 1: a-b
//   out_valid/out_ready result handshake
//   s                   result word
//   flags               {invalid, overflow, inexact}
module fp_addsub_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] a,
    input  logic [EXP_W+FRAC_W:0] b,
    input  logic                  op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] s,
    output logic [2:0]            flags
);

    localparam int unsigned W = 1 + EXP_W + FRAC_W;
    // Significand with hidden bit plus guard, round and sticky positions.
    localparam int unsigned N = FRAC_W + 4;
    localparam logic [EXP_W-1:0] ExpOnes = '1;
    localparam logic [W-1:0] QNaN = {1'b0, ExpOnes, 1'b1, {(FRAC_W-1){1'b0}}};

    // ---------------------------------------------------------------- handshake
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic load1, load2, load3;

    always_comb begin
        load3    = !v3_q || out_ready;
        load2    = !v2_q || load3;
        load1    = !v1_q || load2;
        in_ready = load1;
        v1_d     = load1 ? in_valid : v1_q;
        v2_d     = load2 ? v1_q : v2_q;
        v3_d     = load3 ? v2_q : v3_q;
    end

    // ---------------------------------------------------------------- S1 comb
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, e_big, e_small, diff;
    logic [FRAC_W:0]  ma, mb, m_big, m_small;
    logic             a_nan, b_nan, a_inf, b_inf, a_ge;
    logic [N-1:0]     ext_s, shifted, mask, m_align;
    logic             spec_c;
    logic [W-1:0]     sval_c;
    logic [2:0]       sflg_c;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ op;
        ea     = a[W-2:FRAC_W];
        eb     = b[W-2:FRAC_W];
        a_nan  = (ea == ExpOnes) && (a[FRAC_W-1:0] != '0);
        b_nan  = (eb == ExpOnes) && (b[FRAC_W-1:0] != '0);
        a_inf  = (ea == ExpOnes) && (a[FRAC_W-1:0] == '0);
        b_inf  = (eb == ExpOnes) && (b[FRAC_W-1:0] == '0);
        // Subnormals use effective exponent 1 with a zero hidden bit.
        ea_eff = (ea == '0) ? EXP_W'(1) : ea;
        eb_eff = (eb == '0) ? EXP_W'(1) : eb;
        ma     = {ea != '0, a[FRAC_W-1:0]};
        mb     = {eb != '0, b[FRAC_W-1:0]};
        a_ge   = {ea_eff, ma} >= {eb_eff, mb};
        e_big   = a_ge ? ea_eff : eb_eff;
        e_small = a_ge ? eb_eff : ea_eff;
        m_big   = a_ge ? ma : mb;
        m_small = a_ge ? mb : ma;
        diff    = e_big - e_small;
        ext_s   = {m_small, 3'b000};
        shifted = ext_s >> diff;
        // Bits pushed past position 0 collapse into sticky; a shift beyond N
        // leaves mask all-ones, so a fully shifted-out operand still sets sticky.
        mask    = ~({N{1'b1}} << diff);
        m_align = {shifted[N-1:1], shifted[0] | (|(ext_s & mask))};

        spec_c = 1'b1;
        sval_c = '0;
        sflg_c = '0;
        if (a_nan || b_nan) begin
            sval_c = QNaN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            sval_c = QNaN;
            sflg_c = 3'b100;
        end else if (a_inf) begin
            sval_c = {sa, ExpOnes, {FRAC_W{1'b0}}};
        end else if (b_inf) begin
            sval_c = {sb, ExpOnes, {FRAC_W{1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic             spec1_q, sign1_q, sub1_q, neg1_q;
    logic [W-1:0]     sval1_q;
    logic [2:0]       sflg1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [N-1:0]     mb1_q, ms1_q;

    always_ff @(posedge clk) begin
        if (load1 && in_valid) begin
            spec1_q <= spec_c;
            sval1_q <= sval_c;
            sflg1_q <= sflg_c;
            sign1_q <= a_ge ? sa : sb;
            sub1_q  <= sa ^ sb;
            neg1_q  <= sa & sb;
            exp1_q  <= e_big;
            mb1_q   <= {m_big, 3'b000};
            ms1_q   <= m_align;
        end
    end

    // ---------------------------------------------------------------- S2 comb
    logic [N:0]       sum;
    logic [31:0]      lz, e_lim, shamt;
    logic [N-1:0]     norm;
    logic [EXP_W:0]   exp_n;
    logic             sign_n;

    always_comb begin
        sum = sub1_q ? ({1'b0, mb1_q} - {1'b0, ms1_q}) : ({1'b0, mb1_q} + {1'b0, ms1_q});
        lz  = N;
        for (int i = 0; i < N; i++) begin
            if (sum[i]) lz = N - 1 - i;
        end
        e_lim = 32'(exp1_q) - 32'd1;
        shamt = '0;
        if (sum[N]) begin
            norm  = {sum[N:2], sum[1] | sum[0]};
            exp_n = {1'b0, exp1_q} + 1'b1;
        end else begin
            // Left shift stops at exponent 1; anything left unnormalised is subnormal.
            shamt = (lz < e_lim) ? lz : e_lim;
            norm  = sum[N-1:0] << shamt;
            exp_n = (EXP_W+1)'(32'(exp1_q) - shamt);
            if (!norm[N-1]) exp_n = '0;
        end
        sign_n = (sum == '0) ? neg1_q : sign1_q;
    end

    logic             spec2_q, sign2_q;
    logic [W-1:0]     sval2_q;
    logic [2:0]       sflg2_q;
    logic [EXP_W:0]   exp2_q;
    logic [N-1:0]     m2_q;

    always_ff @(posedge clk) begin
        if (load2 && v1_q) begin
            spec2_q <= spec1_q;
            sval2_q <= sval1_q;
            sflg2_q <= sflg1_q;
            sign2_q <= sign_n;
            exp2_q  <= exp_n;
            m2_q    <= norm;
        end
    end

    // ---------------------------------------------------------------- S3 comb
    logic              rnd, inexact, ovf;
    logic [FRAC_W+1:0] mant_r;
    logic [EXP_W:0]    exp_r;
    logic [FRAC_W-1:0] frac_r;
    logic [W-1:0]      res_c;
    logic [2:0]        flg_c;

    always_comb begin
        rnd     = m2_q[2] & (m2_q[1] | m2_q[0] | m2_q[3]);
        inexact = |m2_q[2:0];
        mant_r  = {1'b0, m2_q[N-1:3]} + {{(FRAC_W+1){1'b0}}, rnd};
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (exp2_q == '0) exp_r = {{EXP_W{1'b0}}, mant_r[FRAC_W]};
        else              exp_r = exp2_q + {{EXP_W{1'b0}}, mant_r[FRAC_W+1]};
        frac_r = mant_r[FRAC_W+1] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
        ovf    = exp_r >= {1'b0, ExpOnes};
        if (spec2_q) begin
            res_c = sval2_q;
            flg_c = sflg2_q;
        end else if (ovf) begin
            res_c = {sign2_q, ExpOnes, {FRAC_W{1'b0}}};
            flg_c = 3'b011;
        end else begin
            res_c = {sign2_q, exp_r[EXP_W-1:0], frac_r};
            flg_c = {2'b00, inexact};
        end
    end

    logic [W-1:0] s_q;
    logic [2:0]   flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            s_q     <= '0;
            flags_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (load3 && v2_q) begin
                s_q     <= res_c;
                flags_q <= flg_c;
            end
        end
    end

    assign out_valid = v3_q;
    assign s         = s_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (single-precision configuration).
// Expected results come from a vector table; a scoreboard queue is filled on
// every input transfer and drained on every output transfer.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .flags     (flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] s;
        logic [2:0]  f;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic [2:0]  f;
        int          id;
    } exp_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    exp_t sbq [$];
    exp_t cur_exp;

    int n_vec = 0;
    int n_err = 0;

    logic        holding = 1'b0;
    logic [31:0] hold_s;
    logic [2:0]  hold_f;

    function automatic vec_t mk(logic [31:0] a_, logic [31:0] b_, logic op_,
                                logic [31:0] s_, logic [2:0] f_);
        vec_t v;
        v.a = a_; v.b = b_; v.op = op_; v.s = s_; v.f = f_;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: handshake signals are stable at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("stall_s_stable", s, hold_s);
                chk("stall_flags_stable", {29'b0, flags}, {29'b0, hold_f});
            end
            holding = out_valid && !out_ready;
            hold_s  = s;
            hold_f  = flags;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, want no output", s);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk($sformatf("result_s[%0d]", e.id), s, e.s);
                    chk($sformatf("result_flags[%0d]", e.id), {29'b0, flags}, {29'b0, e.f});
                end
            end
            if (in_valid && in_ready) sbq.push_back(cur_exp);
        end
    end

    task automatic present(input int id);
        a          = vecs[id].a;
        b          = vecs[id].b;
        op         = vecs[id].op;
        cur_exp.s  = vecs[id].s;
        cur_exp.f  = vecs[id].f;
        cur_exp.id = id;
    endtask

    // Holds in_valid until the vector is accepted; leaves in_valid high.
    task automatic send(input int id);
        bit took = 1'b0;
        int g    = 0;
        present(id);
        in_valid = 1'b1;
        while (!took && g < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout[%0d]: in_ready stayed 0, want 1", id);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_pending", sbq.size(), 0);
    endtask

    int bp_ids [6] = '{4, 6, 7, 8, 12, 13};

    initial begin
        vecs[0]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
        vecs[1]  = mk(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        vecs[2]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        vecs[3]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        vecs[4]  = mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        vecs[5]  = mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        vecs[6]  = mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        vecs[7]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        vecs[8]  = mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        vecs[9]  = mk(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        vecs[10] = mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        vecs[11] = mk(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
        vecs[12] = mk(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 3'b000);
        vecs[13] = mk(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        vecs[14] = mk(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
        vecs[15] = mk(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
        vecs[16] = mk(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000);
        vecs[17] = mk(32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 3'b001);
        vecs[18] = mk(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b001);
        vecs[19] = mk(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
        vecs[20] = mk(32'h4B7FFFFF, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000);
        vecs[21] = mk(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001);

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
        cur_exp = '{s: '0, f: '0, id: -1};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_s", s, 32'd0);
        chk("reset_flags", {29'b0, flags}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: out_valid rises exactly three cycles after the transfer
        @(posedge clk);
        #1;
        present(0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_cycle3", {31'b0, out_valid}, 32'd1);
        drain();

        // Table, one at a time
        for (int i = 0; i < NV; i++) begin
            send(i);
            in_valid = 1'b0;
            drain();
        end

        // Table, full rate
        for (int i = 0; i < NV; i++) send(i);
        in_valid = 1'b0;
        drain();

        // Backpressure: consumer stalls for 5 cycles while 6 ops are offered
        out_ready = 1'b0;
        begin
            int idx = 0;
            for (int c = 0; c < 5; c++) begin
                present(bp_ids[idx]);
                in_valid = 1'b1;
                @(negedge clk);
                chk("bp_in_ready", {31'b0, in_ready}, (c < 3) ? 32'd1 : 32'd0);
                if (in_ready) idx++;
                @(posedge clk);
                #1;
            end
            chk("bp_accepted", idx, 3);
            out_ready = 1'b1;
            while (idx < 6) begin
                send(bp_ids[idx]);
                idx++;
            end
        end
        in_valid = 1'b0;
        drain();

        // Reset with two ops in flight: neither may emerge
        send(0);
        send(12);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_output", {31'b0, out_valid}, 32'd0);
        send(16);
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation still running, want finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor. It is the streaming successor to the team's single-cycle single-precision adder and sits between operand producers and result consumers in the arithmetic datapath. Exponent and fraction widths are configurable, and it supports a per-transaction add/sub select. It provides full special-value handling (±0, subnormal, ±inf, NaN), round-to-nearest-even, and exception flags, behind a valid/ready handshake with backpressure.

## Interface
- EXP_W, 8: exponent field width, minimum 4.
- FRAC_W, 23: stored fraction width, minimum 4. Word width W = 1+EXP_W+FRAC_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  1  0: a+b, 1: a−b (b sign inverted before processing).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- s  out  W  result.
- flags  out  3  {invalid, overflow, inexact}.

## Operation
- Three register stages, fixed:
  - S1 (unpack/align): decode classes; subnormal effective exponent = 1 with hidden bit 0; swap so the larger magnitude is first; right-shift the smaller significand by the exponent difference into guard, round and sticky bits. Sticky = OR of all bits shifted out, including shifts ≥ FRAC_W+3.
  - S2 (add/normalise): effective add or subtract on FRAC_W+4-bit significands. Normalise either with a 1-bit right shift on carry-out or with a leading-one left shift, clamped so the exponent does not go below 1. A result that is still denormalised encodes exponent 0.
  - S3 (round/pack): RNE using guard, round and sticky. Rounding carry increments the exponent. Pack fields and flags.
- Specials, resolved in S1 and carried as a bypass:
  - Any NaN operand → canonical qNaN {0, all-ones, 1 followed by zeros}.
  - +inf + −inf (after op) → qNaN with invalid=1.
  - inf ± finite → that inf.
- Exact zero result: −0 only when both effective signs are negative, otherwise +0.
- Overflow: biased exponent ≥ all-ones after rounding → ±inf, overflow=1, inexact=1.
- inexact=1 whenever any discarded bit (guard, round or sticky) is nonzero, or overflow occurs.
- Subnormal results are produced exactly, with no flush-to-zero. No underflow flag.

## Timing
- Reset: out_valid=0, s=0, flags=0, all stage valids cleared. in_ready=1 in the first cycle after reset is deasserted.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: 3 cycles from input transfer to out_valid when there is no stall. Throughput is 1 op/cycle.
- Stage advance: stage k loads when it is empty or when stage k+1 loads or drains in the same cycle.
  - The S3 register drains on the output transfer.
  - in_ready = !v1 || S1 advances. It is combinationally dependent on out_ready. Max occupancy is 3.
- While out_valid=1 and out_ready=0, s and flags hold stable.
- Simultaneous input and output transfer with a full pipe is legal and loses nothing.
- Results leave in acceptance order.
- rst asserted mid-stream discards all in-flight ops. out_valid=0 on the next edge.
- a, b and op are sampled only on an input transfer.

## Test plan
- 3F800000+3F800000, op=0 → s=40000000, flags=000, out_valid exactly 3 cycles after transfer. Also 40400000, op=1, 3F800000 → 40000000.
- 3F800000−3F800000 → 00000000. 80000000+80000000 → 80000000. 00000001+00000001 → 00000002 (subnormal), flags=000.
- RNE: 3F800000+33800000 → 3F800000, inexact=1 (tie to even). 3F800001+33800000 → 3F800002, inexact=1.
- 7F7FFFFF+7F7FFFFF → 7F800000, flags=011. 7F800000−7F800000 → 7FC00000, flags=100. 7FC00001+3F800000 → 7FC00000.
- Backpressure: stream 6 ops back-to-back with out_ready=0 for 5 cycles. Required: in_ready falls after 3 accepts, s is stable while stalled, all 6 results emerge in order once out_ready=1, and full-rate input with out_ready=1 loses nothing.
- Assert rst with 2 ops in flight → out_valid=0 on the next cycle. Neither op ever appears. in_ready=1 after reset deasserts.
